multi_button_debounce: RTL and testbench
========================================

# multi_button_debounce

Parametrised multi-channel button conditioner for the dino player front end. Each channel synchronises a raw button input, stretches it into a clean level held for HOLD countdown ticks after release, and emits one-cycle press, release and long-press pulses. It sits between the chip input pins and the game controller FSM, replacing per-button single-channel debounce instances.

## Interface
Parameters:
- NUM_CH, 2: number of independent button channels.
- CNT_W, 4: hold counter width.
- HOLD, 15: counter load value; must satisfy 1 ≤ HOLD ≤ 2^CNT_W − 1.
- SYNC_STAGES, 2: synchroniser depth; must be ≥ 1.
- LONG_TICKS, 8: held ticks before btn_long fires; must be ≥ 1. Counter width is clog2(LONG_TICKS+1).

Ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, synchronous and active-low.
- tick_en, in, 1: countdown enable strobe, shared by all channels.
- btn_in, in, NUM_CH: raw asynchronous button inputs, active-high.
- btn_level, out, NUM_CH: debounced level.
- btn_press, out, NUM_CH: one-cycle pulse on a btn_level rise.
- btn_release, out, NUM_CH: one-cycle pulse on a btn_level fall.
- btn_long, out, NUM_CH: one-cycle pulse when a hold reaches LONG_TICKS.

## Operation
Channels are fully independent. Per channel:
- **Synchroniser:** SYNC_STAGES flops, reset 0; its last stage is `s`.
- **Hold counter `cnt`:**
  - If `s` = 1, load HOLD.
  - Else if tick_en and cnt ≠ 0, decrement.
  - Otherwise hold.
  - Load has priority over decrement when tick_en coincides with `s` = 1.
  - No wrap below 0.
- **Level:** btn_level = (cnt ≠ 0), decoded combinationally from the register.
- **Edge pulses:** `lvl_d` is a registered copy of btn_level.
  - btn_press = level & ~lvl_d.
  - btn_release = ~level & lvl_d.
  - Press and release are mutually exclusive per channel.
- **Long-press counter `lc`:**
  - If `s` = 0, clear to 0.
  - Else if tick_en and lc < LONG_TICKS, increment. It saturates at LONG_TICKS.
  - btn_long pulses in the cycle after `lc` transitions from LONG_TICKS−1 to LONG_TICKS (registered output).
  - Exactly one btn_long per continuous hold, regardless of hold length.
  - A glitch low in `s` clears `lc`; a new hold can then fire again.
- **Reset:** rst_n = 0 at a clk edge clears the synchroniser, cnt, lvl_d, lc and the btn_long register.
  - Every output reads 0 from that edge onward.
  - Reset mid-press produces no release pulse.
  - After rst_n rises, a still-held button produces a fresh press pulse after the normal latency.

## Timing
- Let btn_in rise before edge E0.
  - `s` = 1 after edge E0+SYNC_STAGES−1.
  - cnt = HOLD after edge E0+SYNC_STAGES.
  - btn_level and btn_press are high in the cycle after that edge. Press latency is SYNC_STAGES+1 cycles.
  - btn_press lasts exactly one cycle.
- Release: after the last cycle with `s` = 1, btn_level stays high until HOLD tick_en strobes have been seen with `s` = 0.
  - btn_level falls in the cycle after the edge where cnt reaches 0.
  - btn_release is high in that same cycle.
- tick_en held high continuously: release delay is exactly HOLD cycles after `s` falls.
- tick_en never asserted: level is held indefinitely.
- btn_long: asserted the cycle after the edge on which the LONG_TICKS-th tick_en with `s` = 1 is counted.
- Bounce (`s` toggling) while cnt ≠ 0 reloads the counter. It produces no extra press/release pulses.

## Structure
- Shared package dino_input_pkg contains:
  - NUM_BTN = 2.
  - Channel indices BTN_JUMP = 0, BTN_DUCK = 1.
  - Default HOLD and LONG_TICKS constants.
- Sub-module debounce_channel contains one channel: synchroniser, cnt, lvl_d, lc.
- The top level instantiates NUM_CH debounce_channel copies with a generate loop and concatenates their outputs.
- Parameter legality is checked at elaboration; an illegal set is an error.

## Test plan
Defaults: NUM_CH = 2, CNT_W = 4, HOLD = 15, SYNC_STAGES = 2, LONG_TICKS = 8.
- **Press/release, tick_en = 1 constant:** btn_in[0] high for 5 cycles.
  - btn_press[0] pulses 3 cycles after the rise.
  - btn_level[0] stays high through the hold, plus 15 cycles after `s` falls.
  - btn_release[0] pulses once; channel 1 stays all-zero.
- **Bounce:** btn_in[1] toggles every cycle for 10 cycles, then is held low, with tick_en = 1.
  - Exactly one btn_press[1] and one btn_release[1].
  - Level falls 15 cycles after the last high `s`.
- **Long press:** btn_in[0] held with tick_en every 4th cycle.
  - btn_long[0] pulses once, one cycle after the 8th counted tick.
  - No further btn_long while held.
  - Release and re-press gives one more btn_long.
- **tick_en = 0:** press, then release btn_in[0].
  - btn_level[0] stays 1 for 100+ cycles.
  - Enabling tick_en = 1 then drops it after 15 cycles.
- **Reset mid-hold:** rst_n low for 1 cycle while btn_level[0] = 1.
  - All outputs are 0 the cycle after the edge, and no release pulse.
  - With btn_in[0] still high, a new press follows 3 cycles after rst_n rises.

Source files
------------

// File: rtl/dino_input_pkg.sv
// Shared constants and types for the dino player input front end.
//   - NUM_BTN / BTN_JUMP / BTN_DUCK : button channel map
//   - DEF_*                          : default conditioner tuning
//   - btn_evt_t                      : per-channel conditioned outputs
//   - lc_width / params_ok           : elaboration-time helpers
package dino_input_pkg;

  localparam int NUM_BTN  = 2;
  localparam int BTN_JUMP = 0;
  localparam int BTN_DUCK = 1;

  localparam int DEF_CNT_W       = 4;
  localparam int DEF_HOLD        = 15;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LONG_TICKS  = 8;

  // Conditioned view of one button; 'rel'/'lng' avoid SV keywords.
  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
    logic lng;
  } btn_evt_t;

  // Long-press counter must hold the value LONG_TICKS itself (saturation point).
  function automatic int lc_width(input int long_ticks);
    return (long_ticks < 1) ? 1 : $clog2(long_ticks + 1);
  endfunction

  function automatic bit params_ok(input int cnt_w, input int hold,
                                   input int sync_stages, input int long_ticks);
    return (cnt_w >= 1) && (cnt_w <= 31) && (hold >= 1) &&
           (hold <= ((1 << cnt_w) - 1)) && (sync_stages >= 1) &&
           (long_ticks >= 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button conditioner channel.
//   clk, rst_n : clock, synchronous active-low reset
//   tick_en    : countdown / long-press tick strobe
//   btn        : raw asynchronous button, active-high
//   evt        : {lvl, press, rel, lng}
// Synchroniser -> hold counter (level stretch) -> edge pulses, plus a
// saturating long-press counter with a registered one-shot output.
module debounce_channel
  import dino_input_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD        = DEF_HOLD,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LONG_TICKS  = DEF_LONG_TICKS
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick_en,
  input  logic     btn,
  output btn_evt_t evt
);

  localparam int                LC_W   = lc_width(LONG_TICKS);
  localparam logic [CNT_W-1:0]  HOLD_V = CNT_W'(HOLD);
  localparam logic [LC_W-1:0]   LONG_V = LC_W'(LONG_TICKS);
  localparam logic [LC_W-1:0]   LONG_M1 = LC_W'(LONG_TICKS - 1);

  if (!params_ok(CNT_W, HOLD, SYNC_STAGES, LONG_TICKS)) begin : g_bad_params
    $error("debounce_channel: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   sync_in;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic                   lvl;
  logic                   lvl_d;
  logic [LC_W-1:0]        lc;
  logic                   long_q;

  // Shift in at bit 0; the oldest sample is the synchronised value.
  assign sync_in = {sync_q, btn};
  assign s       = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_in[SYNC_STAGES-1:0];
  end

  // Hold counter: any high sample reloads, so bounce only extends the level.
  always_ff @(posedge clk) begin
    if (!rst_n)                    cnt <= '0;
    else if (s)                    cnt <= HOLD_V;
    else if (tick_en && cnt != '0) cnt <= cnt - CNT_W'(1);
  end

  assign lvl = (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) lvl_d <= 1'b0;
    else        lvl_d <= lvl;
  end

  // Long-press: saturating at LONG_TICKS gives one pulse per continuous hold;
  // any low sample clears it so the next hold can fire again.
  always_ff @(posedge clk) begin
    if (!rst_n)                     lc <= '0;
    else if (!s)                    lc <= '0;
    else if (tick_en && lc < LONG_V) lc <= lc + LC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) long_q <= 1'b0;
    else        long_q <= s & tick_en & (lc == LONG_M1);
  end

  always_comb begin
    evt       = '0;
    evt.lvl   = lvl;
    evt.press = lvl & ~lvl_d;
    evt.rel   = ~lvl & lvl_d;
    evt.lng   = long_q;
  end

endmodule

// File: rtl/multi_button_debounce.sv
// Multi-channel button conditioner for the dino player front end.
//   clk, rst_n  : clock, synchronous active-low reset
//   tick_en     : shared countdown strobe
//   btn_in      : raw buttons [NUM_CH-1:0], active-high, asynchronous
//   btn_level   : debounced level per channel
//   btn_press   : one-cycle pulse on level rise
//   btn_release : one-cycle pulse on level fall
//   btn_long    : one-cycle pulse once per hold reaching LONG_TICKS ticks
module multi_button_debounce
  import dino_input_pkg::*;
#(
  parameter int NUM_CH      = NUM_BTN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD        = DEF_HOLD,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LONG_TICKS  = DEF_LONG_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_long
);

  if (NUM_CH < 1 || !params_ok(CNT_W, HOLD, SYNC_STAGES, LONG_TICKS)) begin : g_bad_params
    $error("multi_button_debounce: illegal parameter set");
  end

  btn_evt_t evt [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .HOLD       (HOLD),
      .SYNC_STAGES(SYNC_STAGES),
      .LONG_TICKS (LONG_TICKS)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_en(tick_en),
      .btn    (btn_in[i]),
      .evt    (evt[i])
    );

    assign btn_level[i]   = evt[i].lvl;
    assign btn_press[i]   = evt[i].press;
    assign btn_release[i] = evt[i].rel;
    assign btn_long[i]    = evt[i].lng;
  end

endmodule

// File: tb/tb_multi_button_debounce.sv
module tb_multi_button_debounce;
  import dino_input_pkg::*;

  localparam int NCH  = NUM_BTN;
  localparam int HOLD = DEF_HOLD;
  localparam int SS   = DEF_SYNC_STAGES;
  localparam int LT   = DEF_LONG_TICKS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick_en;
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] btn_level, btn_press, btn_release, btn_long;

  always #5 clk = ~clk;

  multi_button_debounce #(
    .NUM_CH(NCH), .CNT_W(DEF_CNT_W), .HOLD(HOLD),
    .SYNC_STAGES(SS), .LONG_TICKS(LT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: s is btn_in seen SS edges late; level is "s was high and
  // fewer than HOLD ticks have been seen since"; long fires when the tick count
  // of the current unbroken high run of s reaches exactly LT.
  int unsigned sh      [NCH];
  bit          armed   [NCH];
  int          idle    [NCH];
  int          run_t   [NCH];
  bit          lvl_prev[NCH];
  bit          lng_m   [NCH];
  logic [NCH-1:0] e_lvl, e_prs, e_rel, e_lng;

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        sh[c] = 0; armed[c] = 0; idle[c] = 0; run_t[c] = 0;
        lvl_prev[c] = 0; lng_m[c] = 0;
      end else begin
        bit s_old;
        s_old       = sh[c][SS-1];
        lvl_prev[c] = armed[c];
        lng_m[c]    = s_old && tick_en && (run_t[c] + 1 == LT);
        if (!s_old)       run_t[c] = 0;
        else if (tick_en) run_t[c]++;
        if (s_old) begin
          armed[c] = 1; idle[c] = 0;
        end else if (tick_en && armed[c]) begin
          idle[c]++;
          if (idle[c] == HOLD) armed[c] = 0;
        end
        sh[c] = {sh[c][30:0], btn_in[c]};
      end
      e_lvl[c] = armed[c];
      e_prs[c] = armed[c] && !lvl_prev[c];
      e_rel[c] = !armed[c] && lvl_prev[c];
      e_lng[c] = lng_m[c];
    end
  endtask

  // Observed pulse/level counters for the directed scenarios.
  int n_prs [NCH];
  int n_rel [NCH];
  int n_lng [NCH];
  int n_lvl [NCH];

  task automatic clr_counts();
    for (int c = 0; c < NCH; c++) begin
      n_prs[c] = 0; n_rel[c] = 0; n_lng[c] = 0; n_lvl[c] = 0;
    end
  endtask

  // One clock: model updates at the edge, DUT compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("btn_level",   32'(btn_level),   32'(e_lvl));
    chk("btn_press",   32'(btn_press),   32'(e_prs));
    chk("btn_release", 32'(btn_release), 32'(e_rel));
    chk("btn_long",    32'(btn_long),    32'(e_lng));
    for (int c = 0; c < NCH; c++) begin
      n_prs[c] += int'(btn_press[c]);
      n_rel[c] += int'(btn_release[c]);
      n_lng[c] += int'(btn_long[c]);
      n_lvl[c] += int'(btn_level[c]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until btn_press[ch] is seen; returns the step index (1-based) or -1.
  task automatic wait_press(input int ch, input int budget, output int idx);
    idx = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (btn_press[ch] && idx < 0) begin
        idx = i;
        break;
      end
    end
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; tick_en = 1'b0; btn_in = '0;
    clr_counts();

    // Reset state
    run(3);
    chk("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Press/release with tick_en constantly high
    clr_counts();
    tick_en   = 1'b1;
    btn_in[0] = 1'b1;
    wait_press(0, 10, idx);
    chk("press_latency", 32'(idx), 32'(SS + 1));
    run(5 - idx);
    btn_in[0] = 1'b0;
    run(30);
    chk("pr_press_cnt",   32'(n_prs[0]), 32'd1);
    chk("pr_release_cnt", 32'(n_rel[0]), 32'd1);
    // s high for 5 edges' worth of level, then HOLD-1 more cycles before the fall
    chk("pr_level_cycles", 32'(n_lvl[0]), 32'(5 + HOLD - 1));
    chk("pr_ch1_quiet", 32'(n_prs[1] + n_rel[1] + n_lvl[1] + n_lng[1]), 32'd0);

    // Bounce on channel 1
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      btn_in[1] = (i % 2 == 0);
      step();
    end
    btn_in[1] = 1'b0;
    run(30);
    chk("bounce_press_cnt",   32'(n_prs[1]), 32'd1);
    chk("bounce_release_cnt", 32'(n_rel[1]), 32'd1);

    // Long press with a tick every 4th cycle
    clr_counts();
    btn_in[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick_en = (i % 4 == 3);
      step();
    end
    chk("long_first_hold", 32'(n_lng[0]), 32'd1);
    btn_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick_en = (i % 4 == 3);
      step();
    end
    btn_in[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick_en = (i % 4 == 3);
      step();
    end
    chk("long_second_hold", 32'(n_lng[0]), 32'd2);
    btn_in[0] = 1'b0;
    tick_en   = 1'b1;
    run(30);

    // tick_en held low: level never decays
    clr_counts();
    tick_en   = 1'b0;
    btn_in[0] = 1'b1;
    run(5);
    btn_in[0] = 1'b0;
    run(110);
    chk("notick_level_held", 32'(btn_level[0]), 32'd1);
    tick_en = 1'b1;
    run(HOLD - 1);
    chk("notick_level_before", 32'(btn_level[0]), 32'd1);
    run(1);
    chk("notick_level_after", 32'(btn_level[0]), 32'd0);
    chk("notick_release_cnt", 32'(n_rel[0]), 32'd1);
    run(5);

    // Reset while held
    btn_in[0] = 1'b1;
    run(6);
    chk("rst_pre_level", 32'(btn_level[0]), 32'd1);
    clr_counts();
    rst_n = 1'b0;
    step();
    chk("rst_all_zero", 32'({btn_level, btn_press, btn_release, btn_long}), 32'd0);
    rst_n = 1'b1;
    wait_press(0, 10, idx);
    chk("rst_repress_latency", 32'(idx), 32'(SS + 1));
    chk("rst_no_release", 32'(n_rel[0]), 32'd0);
    btn_in[0] = 1'b0;
    run(30);

    // Randomised traffic, including occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) btn_in[c] = ~btn_in[c];
      tick_en = ($urandom_range(0, 2) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
